// File: rtl/ila_capture_ctrl.sv
// Capture sequencer for the ILA sample buffer core: trigger condition
// evaluation plus an idle/armed/capture/done state machine driving the core.
module ila_capture_ctrl #(
  parameter int TRIG_W   = 4,
  parameter int BUFFER_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [TRIG_W-1:0]   trig_in,
  input  logic [TRIG_W-1:0]   trig_mask,
  input  logic [TRIG_W-1:0]   trig_type,
  input  logic [TRIG_W-1:0]   trig_neg,
  input  logic                trig_mode,
  input  logic                continuous,
  input  logic [BUFFER_W-1:0] n_samples_max,
  input  logic                arm,
  input  logic                abort,
  input  logic                clear,
  output logic                core_trigger,
  output logic                core_enabled,
  output logic                core_rst_soft,
  output logic [1:0]          state,
  output logic                done,
  output logic [BUFFER_W-1:0] captured,
  output logic                trig_seen
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [TRIG_W-1:0]   trig_prev_reg;
  logic [BUFFER_W-1:0] captured_reg, captured_next;
  logic [BUFFER_W-1:0] lim_reg, lim_next;
  logic                trig_seen_reg, trig_seen_next;

  logic [TRIG_W-1:0]   rise, fall, hit;
  logic                cond;
  logic                accept;
  logic [BUFFER_W-1:0] captured_plus;
  logic [BUFFER_W-1:0] lim_sel;

  assign rise = trig_in & ~trig_prev_reg;
  assign fall = ~trig_in & trig_prev_reg;

  genvar gi;
  generate
    for (gi = 0; gi < TRIG_W; gi++) begin : g_hit
      assign hit[gi] = trig_type[gi] ? (trig_neg[gi] ? fall[gi] : rise[gi])
                                     : (trig_in[gi] ^ trig_neg[gi]);
    end
  endgenerate

  // An empty mask must never fire, even though the AND reduction would be 1.
  assign cond = (trig_mask != '0) &&
                (trig_mode ? (&(hit | ~trig_mask)) : (|(hit & trig_mask)));

  assign lim_sel       = (n_samples_max == '0) ? '1 : n_samples_max;
  assign captured_plus = captured_reg + BUFFER_W'(1);

  assign core_enabled = (state_reg == ST_ARMED) || (state_reg == ST_CAPTURE);

  always_comb begin
    core_trigger = 1'b0;
    case (state_reg)
      ST_ARMED:   core_trigger = cond;
      ST_CAPTURE: core_trigger = continuous ? cond : 1'b1;
      default:    core_trigger = 1'b0;
    endcase
  end

  assign accept = core_trigger & core_enabled;

  always_comb begin
    state_next     = state_reg;
    captured_next  = captured_reg;
    trig_seen_next = trig_seen_reg;
    lim_next       = lim_reg;
    core_rst_soft  = 1'b0;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            state_next     = ST_ARMED;
            captured_next  = '0;
            trig_seen_next = 1'b0;
            lim_next       = lim_sel;
            core_rst_soft  = 1'b1;
          end else if (clear) begin
            captured_next  = '0;
            trig_seen_next = 1'b0;
            core_rst_soft  = 1'b1;
          end
        end
        ST_ARMED, ST_CAPTURE: begin
          // Saturate at the limit so the count can never wrap past the core's full point.
          if (accept && (captured_reg != lim_reg)) begin
            captured_next  = captured_plus;
            trig_seen_next = 1'b1;
            state_next     = (captured_plus == lim_reg) ? ST_DONE : ST_CAPTURE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      trig_prev_reg <= '0;
      captured_reg  <= '0;
      lim_reg       <= '0;
      trig_seen_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      trig_prev_reg <= trig_in;
      captured_reg  <= captured_next;
      lim_reg       <= lim_next;
      trig_seen_reg <= trig_seen_next;
    end
  end

  assign state     = state_reg;
  assign done      = (state_reg == ST_DONE);
  assign captured  = captured_reg;
  assign trig_seen = trig_seen_reg;

endmodule

// File: tb/tb_ila_capture_ctrl.sv
// Directed bench for ila_capture_ctrl (TRIG_W=4, BUFFER_W=4) with
// hand-computed expectations for each scenario.
module tb_ila_capture_ctrl;
  localparam int TRIG_W   = 4;
  localparam int BUFFER_W = 4;

  logic                clk;
  logic                rst;
  logic [TRIG_W-1:0]   trig_in, trig_mask, trig_type, trig_neg;
  logic                trig_mode, continuous;
  logic [BUFFER_W-1:0] n_samples_max;
  logic                arm, abort, clear;
  logic                core_trigger, core_enabled, core_rst_soft;
  logic [1:0]          state;
  logic                done;
  logic [BUFFER_W-1:0] captured;
  logic                trig_seen;

  int passed = 0;
  int total  = 0;

  ila_capture_ctrl #(.TRIG_W(TRIG_W), .BUFFER_W(BUFFER_W)) dut (
    .clk(clk), .rst(rst), .trig_in(trig_in), .trig_mask(trig_mask),
    .trig_type(trig_type), .trig_neg(trig_neg), .trig_mode(trig_mode),
    .continuous(continuous), .n_samples_max(n_samples_max), .arm(arm),
    .abort(abort), .clear(clear), .core_trigger(core_trigger),
    .core_enabled(core_enabled), .core_rst_soft(core_rst_soft),
    .state(state), .done(done), .captured(captured), .trig_seen(trig_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; trig_in = '0; trig_mask = '0; trig_type = '0; trig_neg = '0;
    trig_mode = 1'b0; continuous = 1'b0; n_samples_max = '0;
    arm = 1'b0; abort = 1'b0; clear = 1'b0;
    cyc(); cyc();
    total++; if (state !== 2'd0) $display("FAIL reset_state_in_reset: got %0d expected 0", state); else passed++;
    rst = 1'b1;
    cyc();
    total++; if (state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", state); else passed++;
    total++; if (core_enabled !== 1'b0) $display("FAIL reset_enabled: got %0d expected 0", core_enabled); else passed++;
    total++; if (core_trigger !== 1'b0) $display("FAIL reset_trigger: got %0d expected 0", core_trigger); else passed++;
    total++; if (captured !== 4'd0) $display("FAIL reset_captured: got %0d expected 0", captured); else passed++;
    total++; if (core_rst_soft !== 1'b0) $display("FAIL reset_rst_soft: got %0d expected 0", core_rst_soft); else passed++;
    total++; if (done !== 1'b0 || trig_seen !== 1'b0) $display("FAIL reset_done_seen: got %0d%0d expected 00", done, trig_seen); else passed++;
    $display("test_reset done");
  endtask

  task automatic test_single_shot();
    trig_mask = 4'b0001; trig_type = 4'b0001; trig_neg = '0; trig_mode = 1'b0;
    continuous = 1'b0; n_samples_max = 4'd5; trig_in = '0;
    arm = 1'b1; #1;
    total++; if (core_rst_soft !== 1'b1) $display("FAIL ss_arm_rst_soft: got %0d expected 1", core_rst_soft); else passed++;
    total++; if (core_trigger !== 1'b0) $display("FAIL ss_arm_trigger: got %0d expected 0", core_trigger); else passed++;
    cyc(); arm = 1'b0; #1;
    total++; if (state !== 2'd1) $display("FAIL ss_armed: got %0d expected 1", state); else passed++;
    total++; if (core_rst_soft !== 1'b0) $display("FAIL ss_rst_soft_after: got %0d expected 0", core_rst_soft); else passed++;
    total++; if (core_enabled !== 1'b1) $display("FAIL ss_enabled: got %0d expected 1", core_enabled); else passed++;
    for (int i = 0; i < 4; i++) cyc();
    total++; if (state !== 2'd1 || core_trigger !== 1'b0) $display("FAIL ss_wait: got state %0d trig %0d expected 1 0", state, core_trigger); else passed++;
    trig_in = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (core_trigger !== 1'b1) $display("FAIL ss_trigger_%0d: got %0d expected 1", i, core_trigger); else passed++;
      cyc();
    end
    #1;
    total++; if (state !== 2'd3 || done !== 1'b1) $display("FAIL ss_done: got state %0d done %0d expected 3 1", state, done); else passed++;
    total++; if (captured !== 4'd5) $display("FAIL ss_captured: got %0d expected 5", captured); else passed++;
    total++; if (core_trigger !== 1'b0 || core_enabled !== 1'b0) $display("FAIL ss_idle_outputs: got %0d%0d expected 00", core_trigger, core_enabled); else passed++;
    total++; if (trig_seen !== 1'b1) $display("FAIL ss_trig_seen: got %0d expected 1", trig_seen); else passed++;
    $display("test_single_shot done");
  endtask

  task automatic test_and_levels();
    trig_mask = 4'b0011; trig_neg = 4'b0010; trig_type = '0; trig_mode = 1'b1;
    continuous = 1'b1; n_samples_max = 4'd3; trig_in = 4'b0011;
    arm = 1'b1;
    cyc(); arm = 1'b0;
    n_samples_max = 4'd1;  // must not affect the latched limit
    #1;
    total++; if (state !== 2'd1 || core_trigger !== 1'b0) $display("FAIL and_armed: got state %0d trig %0d expected 1 0", state, core_trigger); else passed++;
    for (int k = 0; k < 5; k++) begin
      trig_in = (k % 2 == 0) ? 4'b0001 : 4'b0011;
      #1;
      total++; if (core_trigger !== (k % 2 == 0)) $display("FAIL and_trigger_%0d: got %0d expected %0d", k, core_trigger, (k % 2 == 0)); else passed++;
      cyc();
      total++; if (captured !== 4'(k / 2 + 1)) $display("FAIL and_captured_%0d: got %0d expected %0d", k, captured, k / 2 + 1); else passed++;
      total++; if (state !== ((k == 4) ? 2'd3 : 2'd2)) $display("FAIL and_state_%0d: got %0d expected %0d", k, state, (k == 4) ? 3 : 2); else passed++;
    end
    $display("test_and_levels done");
  endtask

  task automatic test_zero_limit();
    int acc;
    acc = 0;
    trig_mask = 4'b0001; trig_type = '0; trig_neg = '0; trig_mode = 1'b0;
    continuous = 1'b0; n_samples_max = 4'd0; trig_in = 4'b0001;
    arm = 1'b1; #1;
    total++; if (core_rst_soft !== 1'b1 || core_trigger !== 1'b0) $display("FAIL zl_arm: got rst_soft %0d trig %0d expected 1 0", core_rst_soft, core_trigger); else passed++;
    cyc(); arm = 1'b0; #1;
    for (int i = 0; i < 40 && state !== 2'd3; i++) begin
      if (core_trigger && core_enabled) acc++;
      cyc();
    end
    total++; if (acc != 15) $display("FAIL zl_accepts: got %0d expected 15", acc); else passed++;
    total++; if (state !== 2'd3) $display("FAIL zl_state: got %0d expected 3", state); else passed++;
    total++; if (captured !== 4'd15) $display("FAIL zl_captured: got %0d expected 15", captured); else passed++;
    cyc(); cyc(); #1;
    total++; if (core_trigger !== 1'b0 || captured !== 4'd15) $display("FAIL zl_after: got trig %0d cap %0d expected 0 15", core_trigger, captured); else passed++;
    $display("test_zero_limit done");
  endtask

  task automatic test_abort();
    trig_mask = 4'b0001; trig_type = '0; trig_neg = '0; trig_mode = 1'b0;
    continuous = 1'b0; n_samples_max = 4'd10; trig_in = 4'b0001;
    arm = 1'b1;
    cyc(); arm = 1'b0;
    cyc(); cyc(); cyc();
    total++; if (captured !== 4'd3 || state !== 2'd2) $display("FAIL ab_pre: got cap %0d state %0d expected 3 2", captured, state); else passed++;
    abort = 1'b1; #1;
    total++; if (core_rst_soft !== 1'b0) $display("FAIL ab_rst_soft: got %0d expected 0", core_rst_soft); else passed++;
    cyc(); abort = 1'b0; #1;
    total++; if (state !== 2'd0) $display("FAIL ab_state: got %0d expected 0", state); else passed++;
    total++; if (captured !== 4'd3 || trig_seen !== 1'b1) $display("FAIL ab_hold: got cap %0d seen %0d expected 3 1", captured, trig_seen); else passed++;
    clear = 1'b1; #1;
    total++; if (core_rst_soft !== 1'b1) $display("FAIL ab_clear_rst_soft: got %0d expected 1", core_rst_soft); else passed++;
    cyc(); clear = 1'b0; #1;
    total++; if (captured !== 4'd0 || trig_seen !== 1'b0 || state !== 2'd0) $display("FAIL ab_cleared: got cap %0d seen %0d state %0d expected 0 0 0", captured, trig_seen, state); else passed++;
    $display("test_abort done");
  endtask

  task automatic test_simultaneous();
    arm = 1'b1; abort = 1'b1; #1;
    total++; if (core_rst_soft !== 1'b0) $display("FAIL sim_arm_abort_rst_soft: got %0d expected 0", core_rst_soft); else passed++;
    cyc(); arm = 1'b0; abort = 1'b0;
    total++; if (state !== 2'd0) $display("FAIL sim_arm_abort_state: got %0d expected 0", state); else passed++;
    arm = 1'b1; clear = 1'b1;
    cyc(); arm = 1'b0; clear = 1'b0;
    total++; if (state !== 2'd1) $display("FAIL sim_arm_clear_state: got %0d expected 1", state); else passed++;
    cyc(); cyc();
    clear = 1'b1; #1;
    total++; if (core_rst_soft !== 1'b0) $display("FAIL sim_clear_in_capture: got %0d expected 0", core_rst_soft); else passed++;
    cyc(); clear = 1'b0;
    total++; if (captured !== 4'd3) $display("FAIL sim_clear_ignored: got %0d expected 3", captured); else passed++;
    arm = 1'b1; #1;
    total++; if (core_rst_soft !== 1'b0) $display("FAIL sim_arm_in_capture: got %0d expected 0", core_rst_soft); else passed++;
    cyc(); arm = 1'b0;
    total++; if (captured !== 4'd4 || state !== 2'd2) $display("FAIL sim_arm_ignored: got cap %0d state %0d expected 4 2", captured, state); else passed++;
    abort = 1'b1; cyc(); abort = 1'b0;
    trig_mask = '0;
    arm = 1'b1; cyc(); arm = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    total++; if (state !== 2'd1 || captured !== 4'd0 || core_trigger !== 1'b0) $display("FAIL sim_mask0_or: got state %0d cap %0d trig %0d expected 1 0 0", state, captured, core_trigger); else passed++;
    trig_mode = 1'b1; #1;
    total++; if (core_trigger !== 1'b0) $display("FAIL sim_mask0_and: got %0d expected 0", core_trigger); else passed++;
    abort = 1'b1; cyc(); abort = 1'b0;
    trig_mask = 4'b0001; trig_mode = 1'b0;
    arm = 1'b1; cyc(); arm = 1'b0;
    cyc(); cyc();
    total++; if (state !== 2'd2 || captured !== 4'd2) $display("FAIL sim_pre_rst: got state %0d cap %0d expected 2 2", state, captured); else passed++;
    rst = 1'b0; #1;
    total++; if (state !== 2'd0 || captured !== 4'd0 || trig_seen !== 1'b0) $display("FAIL sim_async_rst: got state %0d cap %0d seen %0d expected 0 0 0", state, captured, trig_seen); else passed++;
    cyc(); rst = 1'b1; cyc();
    total++; if (state !== 2'd0) $display("FAIL sim_after_rst: got %0d expected 0", state); else passed++;
    $display("test_simultaneous done");
  endtask

  task automatic test_edge_limit();
    trig_in = 4'b0100; cyc();
    trig_mask = 4'b0100; trig_type = 4'b0100; trig_neg = 4'b0100; trig_mode = 1'b0;
    continuous = 1'b1; n_samples_max = 4'd2;
    arm = 1'b1; cyc(); arm = 1'b0; #1;
    total++; if (core_trigger !== 1'b0) $display("FAIL fe_no_edge: got %0d expected 0", core_trigger); else passed++;
    trig_in = 4'b0000; #1;
    total++; if (core_trigger !== 1'b1) $display("FAIL fe_fall1: got %0d expected 1", core_trigger); else passed++;
    cyc();
    total++; if (captured !== 4'd1 || state !== 2'd2) $display("FAIL fe_cap1: got cap %0d state %0d expected 1 2", captured, state); else passed++;
    #1;
    total++; if (core_trigger !== 1'b0) $display("FAIL fe_low_hold: got %0d expected 0", core_trigger); else passed++;
    cyc();
    trig_in = 4'b0100; #1;
    total++; if (core_trigger !== 1'b0) $display("FAIL fe_rise: got %0d expected 0", core_trigger); else passed++;
    cyc();
    trig_in = 4'b0000; #1;
    total++; if (core_trigger !== 1'b1) $display("FAIL fe_fall2: got %0d expected 1", core_trigger); else passed++;
    cyc();
    total++; if (captured !== 4'd2 || state !== 2'd3) $display("FAIL fe_done: got cap %0d state %0d expected 2 3", captured, state); else passed++;
    trig_mask = 4'b0001; trig_type = '0; trig_neg = '0; continuous = 1'b0;
    n_samples_max = 4'd1; trig_in = 4'b0001;
    arm = 1'b1; cyc(); arm = 1'b0;
    total++; if (state !== 2'd1) $display("FAIL lim1_armed: got %0d expected 1", state); else passed++;
    cyc();
    total++; if (state !== 2'd3 || captured !== 4'd1 || done !== 1'b1) $display("FAIL lim1_done: got state %0d cap %0d done %0d expected 3 1 1", state, captured, done); else passed++;
    $display("test_edge_limit done");
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_and_levels();
    test_zero_limit();
    test_abort();
    test_simultaneous();
    test_edge_limit();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ila_capture_ctrl.md
Name: ila_capture_ctrl

Overview:
Single-clock capture sequencer for the ILA sample buffer core. It evaluates a configurable multi-bit trigger condition (per-bit mask, level/edge, polarity, AND/OR combine) and runs an arm/capture/done state machine. It drives the core's trigger, enabled and rst_soft inputs, and limits capture to a programmed sample count. It sits between the ILA software registers and the buffer core, and shares the buffer core's clock.

Parameters:
TRIG_W, 4, number of raw trigger inputs
BUFFER_W, 10, buffer address width; must equal the core's BUFFER_W

Ports:
clk  in  1  system clock; also the core's sampling clock
rst  in  1  asynchronous reset, active-low
trig_in  in  TRIG_W  raw trigger bits, synchronous to clk
trig_mask  in  TRIG_W  1 = bit participates in the trigger condition
trig_type  in  TRIG_W  0 = level, 1 = edge
trig_neg  in  TRIG_W  invert the bit: low level, or falling edge
trig_mode  in  1  0 = OR of participating bits, 1 = AND
continuous  in  1  0 = single-shot contiguous capture, 1 = record only cycles where the condition holds
n_samples_max  in  BUFFER_W  capture limit; 0 = 2^BUFFER_W-1
arm  in  1  single-cycle pulse: start capture
abort  in  1  single-cycle pulse: stop capture
clear  in  1  single-cycle pulse: reset counters and buffer pointer
core_trigger  out  1  to core trigger
core_enabled  out  1  to core enabled
core_rst_soft  out  1  to core rst_soft
state  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
done  out  1  high while in DONE
captured  out  BUFFER_W  samples accepted since the last arm or clear
trig_seen  out  1  the trigger condition fired in the current run

Behaviour:
- Reset (rst=0, async): state=IDLE; captured=0; trig_seen=0; trig_prev=0; limit register=0; all outputs 0.
- Edge detection: trig_prev is the trig_in value registered every cycle.
  - Rising edge: trig_in & ~trig_prev. Falling edge: ~trig_in & trig_prev.
  - A first-cycle-after-reset edge is judged against trig_prev=0.
- Per-bit hit[i]:
  - trig_type[i]=0: trig_in[i] ^ trig_neg[i].
  - trig_type[i]=1: rising edge if trig_neg[i]=0, falling edge if trig_neg[i]=1.
- cond (combinational):
  - OR mode: |(hit & mask).
  - AND mode: &(hit | ~mask).
  - trig_mask=0 forces cond=0 in both modes.
- Limit: lim = (n_samples_max==0) ? all-ones : n_samples_max. It is registered when an arm is accepted; later changes to n_samples_max have no effect until the next arm.
- core_enabled = (state==ARMED || state==CAPTURE). It is combinational from state.
- core_trigger (combinational):
  - ARMED: cond.
  - CAPTURE: 1 if continuous=0, cond if continuous=1.
  - IDLE/DONE: 0.
- accept = core_trigger & core_enabled. On each accept, captured increments by 1 on the same clock edge at which the core writes the sample.
- FSM transitions:
  - IDLE: arm -> ARMED. clear -> stay IDLE.
  - ARMED: accept with captured+1==lim -> DONE. Other accept -> CAPTURE. No cond -> stay. trig_seen is set on the first accept.
  - CAPTURE: accept with captured+1==lim -> DONE. Otherwise stay.
  - DONE: stays until arm (-> ARMED) or clear (stay DONE, counters cleared, done held).
- Arm accepted (in IDLE or DONE): captured<=0, trig_seen<=0, lim latched, core_rst_soft=1 combinationally in that cycle. core_trigger is 0 in the arm cycle because state is still IDLE/DONE, so no write races the pointer reset.
- Arm in ARMED or CAPTURE: ignored.
- Clear (IDLE/DONE only): captured<=0, trig_seen<=0, core_rst_soft=1 for that cycle. Clear in ARMED or CAPTURE is ignored.
- Abort from any state: next state IDLE. captured and trig_seen hold their values. No core_rst_soft is generated.
- Priority on simultaneous pulses: abort > arm > clear. Arm+clear in IDLE behaves as arm alone.
- lim == 1: the first accept in ARMED goes directly to DONE with captured=1.
- Counter saturation: lim is at most all-ones and captured stops at lim, so captured never wraps. This matches the core's full flag.
- Latency: the state change is visible one cycle after the qualifying event. core_* outputs are combinational from state and the current inputs.

Test Plan:
- Reset then idle: rst low for 2 cycles, then high, no pulses -> state=0, core_enabled=0, core_trigger=0, captured=0, core_rst_soft=0.
- Single-shot, OR, rising edge on bit0: mask=0001, type=0001, lim=5, arm, then trig_in[0] 0->1 at cycle 10 -> core_rst_soft=1 in the arm cycle only; state ARMED; core_trigger=1 at cycles 10-14; captured=5; state DONE at cycle 15; done=1.
- AND mode, levels with negation: mask=0011, neg=0010, lim=3, continuous=1 -> accept only when trig_in[1:0]=01; a pattern that alternates 01/11 gives captured incrementing every other cycle, then DONE after 3 accepts.
- n_samples_max=0 with BUFFER_W=4, continuous=0 -> exactly 15 accepts, then DONE; captured=15; core_trigger=0 afterwards.
- Abort in CAPTURE with captured=3: abort pulse -> IDLE next cycle, captured stays 3, no core_rst_soft; a later clear -> captured=0 and core_rst_soft pulse.
- Simultaneous events: arm+abort in IDLE -> stays IDLE. arm in CAPTURE -> ignored, count continues. mask=0 with arm -> stays ARMED indefinitely with captured=0. rst asserted mid-CAPTURE -> immediate IDLE and captured=0.
